alu_arbiter: RTL and testbench

//  Shares the single combinational 8-bit ALU between two requesters (0: core execute stage,
//  1: address/branch helper). Requesters are selected round-robin with valid/ready handshakes,
//  and a requester may lock the ALU for a bounded run of consecutive operations. Each accepted

---
 rtl/alu_arbiter_if.sv | 42 ++++
 rtl/alu_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester handshakes, their registered responses and the shared ALU bus.
// The arbiter takes the slave view; the requesters and the ALU together take the master view.
interface alu_arbiter_if #(
  parameter int W   = 8,
  parameter int OPW = 3
);
  logic           req0_valid, req0_lock, req0_lsl_sel, req0_orr_sel, req0_ready;
  logic [OPW-1:0] req0_op;
  logic [W-1:0]   req0_a, req0_b;
  logic           req1_valid, req1_lock, req1_lsl_sel, req1_orr_sel, req1_ready;
  logic [OPW-1:0] req1_op;
  logic [W-1:0]   req1_a, req1_b;

  logic           rsp0_valid, rsp0_zero, rsp0_neg;
  logic [W-1:0]   rsp0_rslt;
  logic           rsp1_valid, rsp1_zero, rsp1_neg;
  logic [W-1:0]   rsp1_rslt;

  logic [OPW-1:0] alu_op;
  logic [W-1:0]   alu_dat_a, alu_dat_b, alu_rslt;
  logic           alu_lsl_sel, alu_orr_sel, alu_zero, alu_neg;

  modport slave (
    input  req0_valid, req0_lock, req0_op, req0_a, req0_b, req0_lsl_sel, req0_orr_sel,
    input  req1_valid, req1_lock, req1_op, req1_a, req1_b, req1_lsl_sel, req1_orr_sel,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rslt, rsp0_zero, rsp0_neg,
    output rsp1_valid, rsp1_rslt, rsp1_zero, rsp1_neg,
    output alu_op, alu_dat_a, alu_dat_b, alu_lsl_sel, alu_orr_sel,
    input  alu_rslt, alu_zero, alu_neg
  );

  modport master (
    output req0_valid, req0_lock, req0_op, req0_a, req0_b, req0_lsl_sel, req0_orr_sel,
    output req1_valid, req1_lock, req1_op, req1_a, req1_b, req1_lsl_sel, req1_orr_sel,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rslt, rsp0_zero, rsp0_neg,
    input  rsp1_valid, rsp1_rslt, rsp1_zero, rsp1_neg,
    input  alu_op, alu_dat_a, alu_dat_b, alu_lsl_sel, alu_orr_sel,
    output alu_rslt, alu_zero, alu_neg
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, with bounded
// lock runs and a one-cycle registered result path back to the owning requester.
module alu_arbiter #(
  parameter int W        = 8,
  parameter int OPW      = 3,
  parameter int MAX_LOCK = 4
) (
  input logic        clk,
  input logic        rst,
  alu_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);

  typedef enum logic [1:0] {OWN_NONE, OWN_0, OWN_1} own_t;

  own_t          lock_own, lock_own_nxt;
  logic [CW-1:0] lock_cnt, lock_cnt_nxt;
  logic          last_gnt, last_gnt_nxt;
  logic          gnt_vld, gnt_id;
  logic [1:0]    v, lk;

  logic [1:0]     rsp_valid, rsp_zero, rsp_neg;
  logic [W-1:0]   rsp_rslt [2];
  logic [OPW-1:0] op_sel;
  logic [W-1:0]   a_sel, b_sel;

  assign v  = {bus.req1_valid, bus.req0_valid};
  assign lk = {bus.req1_lock,  bus.req0_lock};

  // No grant while reset is high, so an op presented during reset is never accepted.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (!rst) begin
      if (lock_own == OWN_0 && v[0] && (lock_cnt < CNT_MAX || !v[1])) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (lock_own == OWN_1 && v[1] && (lock_cnt < CNT_MAX || !v[0])) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end else if (v[0] && v[1]) begin
        gnt_vld = 1'b1;
        gnt_id  = !last_gnt;
      end else if (v[0] || v[1]) begin
        gnt_vld = 1'b1;
        gnt_id  = v[1];
      end
    end
  end

  // A lock taken by a different requester (forced-in winner) starts its own run at 1.
  always_comb begin
    last_gnt_nxt = last_gnt;
    lock_own_nxt = lock_own;
    lock_cnt_nxt = lock_cnt;
    if (gnt_vld) begin
      last_gnt_nxt = gnt_id;
      if (lk[gnt_id]) begin
        lock_own_nxt = gnt_id ? OWN_1 : OWN_0;
        if (lock_own != lock_own_nxt)
          lock_cnt_nxt = CW'(1);
        else if (lock_cnt < CNT_MAX)
          lock_cnt_nxt = lock_cnt + 1'b1;
      end else begin
        lock_own_nxt = OWN_NONE;
        lock_cnt_nxt = '0;
      end
    end else if ((lock_own == OWN_0 && !v[0]) || (lock_own == OWN_1 && !v[1])) begin
      lock_own_nxt = OWN_NONE;
      lock_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b1;
      lock_own <= OWN_NONE;
      lock_cnt <= '0;
    end else begin
      last_gnt <= last_gnt_nxt;
      lock_own <= lock_own_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid   <= '0;
      rsp_zero    <= '0;
      rsp_neg     <= '0;
      rsp_rslt[0] <= '0;
      rsp_rslt[1] <= '0;
    end else begin
      rsp_valid <= '0;
      if (gnt_vld) begin
        rsp_valid[gnt_id] <= 1'b1;
        rsp_rslt[gnt_id]  <= bus.alu_rslt;
        rsp_zero[gnt_id]  <= bus.alu_zero;
        rsp_neg[gnt_id]   <= bus.alu_neg;
      end
    end
  end

  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    bus.alu_lsl_sel = 1'b0;
    bus.alu_orr_sel = 1'b0;
    if (gnt_vld) begin
      op_sel = gnt_id ? bus.req1_op : bus.req0_op;
      a_sel  = gnt_id ? bus.req1_a  : bus.req0_a;
      b_sel  = gnt_id ? bus.req1_b  : bus.req0_b;
      bus.alu_lsl_sel = gnt_id ? bus.req1_lsl_sel : bus.req0_lsl_sel;
      bus.alu_orr_sel = gnt_id ? bus.req1_orr_sel : bus.req0_orr_sel;
    end
  end

  assign bus.alu_op     = op_sel;
  assign bus.alu_dat_a  = a_sel;
  assign bus.alu_dat_b  = b_sel;
  assign bus.req0_ready = gnt_vld && !gnt_id;
  assign bus.req1_ready = gnt_vld && gnt_id;

  assign bus.rsp0_valid = rsp_valid[0];
  assign bus.rsp0_rslt  = rsp_rslt[0];
  assign bus.rsp0_zero  = rsp_zero[0];
  assign bus.rsp0_neg   = rsp_neg[0];
  assign bus.rsp1_valid = rsp_valid[1];
  assign bus.rsp1_rslt  = rsp_rslt[1];
  assign bus.rsp1_zero  = rsp_zero[1];
  assign bus.rsp1_neg   = rsp_neg[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: plays both requesters and the ALU, and checks every cycle against
// a request-level model of the arbitration, lock and response rules.
`timescale 1ns/1ps
module tb_alu_arbiter;
  localparam int W = 8, OPW = 3, MAX_LOCK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.W(W), .OPW(OPW)) bus ();
  alu_arbiter #(.W(W), .OPW(OPW), .MAX_LOCK(MAX_LOCK)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b;
    logic       lsl, orr, lock;
  } req_t;

  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, b,
                                        input logic lsl, orr);
    if (lsl) return a << b[2:0];
    if (orr) return a | b;
    case (op)
      3'b000:         return a & b;
      3'b001, 3'b011: return a - b;
      3'b010:         return a + b;
      default:        return a ^ b;
    endcase
  endfunction

  function automatic req_t mk(input logic [2:0] op, input logic [7:0] a, b,
                              input logic lsl, orr, lock);
    mk = '{op: op, a: a, b: b, lsl: lsl, orr: orr, lock: lock};
  endfunction

  // bench-side ALU
  assign bus.alu_rslt = alu_fn(bus.alu_op, bus.alu_dat_a, bus.alu_dat_b, bus.alu_lsl_sel, bus.alu_orr_sel);
  assign bus.alu_zero = (bus.alu_rslt == 8'd0);
  assign bus.alu_neg  = bus.alu_rslt[7];

  int tests = 0, fails = 0;
  task automatic check(input string name, input logic [31:0] got, exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // requester drivers: hold each request until accepted, then present the next queued one
  req_t q0[$], q1[$];
  req_t r0, r1;
  logic acc0 = 1'b0, acc1 = 1'b0;
  always @(negedge clk) begin
    acc0 <= bus.req0_valid && bus.req0_ready;
    acc1 <= bus.req1_valid && bus.req1_ready;
  end

  initial begin
    bus.req0_valid = 0; bus.req0_lock = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req0_lsl_sel = 0; bus.req0_orr_sel = 0;
    forever begin
      @(posedge clk); #1;
      if (bus.req0_valid && acc0) bus.req0_valid = 1'b0;
      if (!bus.req0_valid && q0.size() > 0) begin
        r0 = q0.pop_front();
        bus.req0_op = r0.op; bus.req0_a = r0.a; bus.req0_b = r0.b;
        bus.req0_lsl_sel = r0.lsl; bus.req0_orr_sel = r0.orr; bus.req0_lock = r0.lock;
        bus.req0_valid = 1'b1;
      end
    end
  end

  initial begin
    bus.req1_valid = 0; bus.req1_lock = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.req1_lsl_sel = 0; bus.req1_orr_sel = 0;
    forever begin
      @(posedge clk); #1;
      if (bus.req1_valid && acc1) bus.req1_valid = 1'b0;
      if (!bus.req1_valid && q1.size() > 0) begin
        r1 = q1.pop_front();
        bus.req1_op = r1.op; bus.req1_a = r1.a; bus.req1_b = r1.b;
        bus.req1_lsl_sel = r1.lsl; bus.req1_orr_sel = r1.orr; bus.req1_lock = r1.lock;
        bus.req1_valid = 1'b1;
      end
    end
  end

  // model: who won last, who holds a lock and how long the current locked run is
  int         m_last = 1, m_owner = -1, m_run = 0;
  logic       e_rv [2] = '{0, 0};
  logic       e_z  [2] = '{0, 0};
  logic       e_n  [2] = '{0, 0};
  logic [7:0] e_r  [2] = '{0, 0};
  int         gnt_log[$];
  logic [8:0] rsp_log0[$], rsp_log1[$];

  always @(negedge clk) begin : model
    req_t cur [2];
    logic vq  [2];
    int   g;
    logic [7:0] r;
    if (bus.req0_ready) gnt_log.push_back(0);
    if (bus.req1_ready) gnt_log.push_back(1);
    if (bus.rsp0_valid) rsp_log0.push_back({bus.rsp0_zero, bus.rsp0_rslt});
    if (bus.rsp1_valid) rsp_log1.push_back({bus.rsp1_zero, bus.rsp1_rslt});
    if (rst) begin
      check("rst_ready0", bus.req0_ready, 0);
      check("rst_ready1", bus.req1_ready, 0);
      check("rst_alu", {bus.alu_op, bus.alu_dat_a, bus.alu_dat_b, bus.alu_lsl_sel, bus.alu_orr_sel}, 0);
      check("rst_rsp0", {bus.rsp0_valid, bus.rsp0_zero, bus.rsp0_neg, bus.rsp0_rslt}, 0);
      check("rst_rsp1", {bus.rsp1_valid, bus.rsp1_zero, bus.rsp1_neg, bus.rsp1_rslt}, 0);
      m_last = 1; m_owner = -1; m_run = 0;
      e_rv = '{0, 0}; e_z = '{0, 0}; e_n = '{0, 0}; e_r = '{0, 0};
    end else begin
      cur[0] = mk(bus.req0_op, bus.req0_a, bus.req0_b, bus.req0_lsl_sel, bus.req0_orr_sel, bus.req0_lock);
      cur[1] = mk(bus.req1_op, bus.req1_a, bus.req1_b, bus.req1_lsl_sel, bus.req1_orr_sel, bus.req1_lock);
      vq[0] = bus.req0_valid;
      vq[1] = bus.req1_valid;
      g = -1;
      if (m_owner >= 0 && vq[m_owner] && (m_run < MAX_LOCK || !vq[1 - m_owner])) g = m_owner;
      else if (vq[0] && vq[1]) g = 1 - m_last;
      else if (vq[0]) g = 0;
      else if (vq[1]) g = 1;

      check("ready0", bus.req0_ready, g == 0);
      check("ready1", bus.req1_ready, g == 1);
      if (g >= 0)
        check("alu_drive", {bus.alu_op, bus.alu_dat_a, bus.alu_dat_b, bus.alu_lsl_sel, bus.alu_orr_sel},
              {cur[g].op, cur[g].a, cur[g].b, cur[g].lsl, cur[g].orr});
      else
        check("alu_idle", {bus.alu_op, bus.alu_dat_a, bus.alu_dat_b, bus.alu_lsl_sel, bus.alu_orr_sel}, 0);
      check("rsp0", {bus.rsp0_valid, bus.rsp0_zero, bus.rsp0_neg, bus.rsp0_rslt}, {e_rv[0], e_z[0], e_n[0], e_r[0]});
      check("rsp1", {bus.rsp1_valid, bus.rsp1_zero, bus.rsp1_neg, bus.rsp1_rslt}, {e_rv[1], e_z[1], e_n[1], e_r[1]});

      e_rv = '{0, 0};
      if (g >= 0) begin
        r = alu_fn(cur[g].op, cur[g].a, cur[g].b, cur[g].lsl, cur[g].orr);
        e_rv[g] = 1'b1; e_r[g] = r; e_z[g] = (r == 8'd0); e_n[g] = r[7];
        m_last = g;
        if (cur[g].lock) begin
          m_run   = (m_owner == g) ? ((m_run < MAX_LOCK) ? m_run + 1 : m_run) : 1;
          m_owner = g;
        end else begin
          m_owner = -1; m_run = 0;
        end
      end else if (m_owner >= 0 && !vq[m_owner]) begin
        m_owner = -1; m_run = 0;
      end
    end
  end

  task automatic clear_logs();
    gnt_log.delete(); rsp_log0.delete(); rsp_log1.delete();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while ((q0.size() > 0 || q1.size() > 0 || bus.req0_valid || bus.req1_valid) && n < 200);
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL %s: timeout waiting for idle", name);
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic check_gnts(input string name, input int exp[$]);
    check({name, "_count"}, gnt_log.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check(name, (i < gnt_log.size()) ? gnt_log[i] : -1, exp[i]);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;

    // T1: lone ADD 10+5
    @(negedge clk); clear_logs();
    q0.push_back(mk(3'b010, 8'd10, 8'd5, 0, 0, 0));
    wait_idle("t1");
    check_gnts("t1_gnt", '{0});
    check("t1_rslt", (rsp_log0.size() > 0) ? rsp_log0[0] : 9'h1ff, {1'b0, 8'd15});

    // T2: both valid from reset, alternate starting with req0
    @(posedge clk); #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(3'b011, 8'd15, 8'd5, 0, 0, 0));
      q1.push_back(mk(3'b001, 8'd20, 8'd20, 0, 0, 0));
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    clear_logs();
    wait_idle("t2");
    check_gnts("t2_gnt", '{0, 1, 0, 1, 0, 1});
    check("t2_rsp0", (rsp_log0.size() > 0) ? rsp_log0[0] : 9'h1ff, {1'b0, 8'd10});
    check("t2_rsp1", (rsp_log1.size() > 0) ? rsp_log1[0] : 9'h1ff, {1'b1, 8'd0});

    // T4: req0 locks for LSL then AND, req1 waits
    clear_logs();
    q0.push_back(mk(3'b000, 8'd4, 8'd2, 1, 0, 1));
    q0.push_back(mk(3'b000, 8'hAA, 8'hCC, 0, 0, 0));
    q1.push_back(mk(3'b010, 8'd1, 8'd2, 0, 0, 0));
    wait_idle("t4");
    check_gnts("t4_gnt", '{0, 0, 1});
    check("t4_lsl", (rsp_log0.size() > 0) ? rsp_log0[0] : 9'h1ff, {1'b0, 8'h10});
    check("t4_and", (rsp_log0.size() > 1) ? rsp_log0[1] : 9'h1ff, {1'b0, 8'h88});
    check("t4_rsp1", (rsp_log1.size() > 0) ? rsp_log1[0] : 9'h1ff, {1'b0, 8'd3});

    // T3: req1 locked run capped at MAX_LOCK, then req0 forced in
    clear_logs();
    for (int i = 0; i < 5; i++) q1.push_back(mk(3'b010, 8'(i), 8'd1, 0, 0, i < 4));
    @(negedge clk);
    q0.push_back(mk(3'b100, 8'hF0, 8'h0F, 0, 0, 0));
    q0.push_back(mk(3'b000, 8'h01, 8'h80, 0, 1, 0));
    wait_idle("t3");
    check_gnts("t3_gnt", '{1, 1, 1, 1, 0, 1, 0});
    check("t3_xor", (rsp_log0.size() > 0) ? rsp_log0[0] : 9'h1ff, {1'b0, 8'hFF});
    check("t3_last1", (rsp_log1.size() > 4) ? rsp_log1[4] : 9'h1ff, {1'b0, 8'd5});

    // T5: idle bus, response data holds
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("t5_alu", {bus.alu_op, bus.alu_dat_a, bus.alu_dat_b, bus.alu_lsl_sel, bus.alu_orr_sel}, 0);
      check("t5_rv", {bus.rsp0_valid, bus.rsp1_valid}, 0);
      check("t5_rsp0_hold", {bus.rsp0_zero, bus.rsp0_neg, bus.rsp0_rslt}, {2'b01, 8'h81});
      check("t5_rsp1_hold", {bus.rsp1_zero, bus.rsp1_neg, bus.rsp1_rslt}, {2'b00, 8'h05});
    end

    // T6: reset in the middle of a req1 lock run
    clear_logs();
    for (int i = 0; i < 4; i++) q1.push_back(mk(3'b010, 8'd10, 8'(i), 0, 0, 1));
    for (int n = 0; gnt_log.size() < 2; n++) begin
      if (n >= 50) begin
        tests++; fails++;
        $display("FAIL t6_wait: only %0d grants seen", gnt_log.size());
        break;
      end
      @(negedge clk); #1;
    end
    q0.push_back(mk(3'b010, 8'd100, 8'd1, 0, 0, 0));
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk); #1;
    check("t6_rsp1_dropped", bus.rsp1_valid, 0);
    check("t6_ready_in_rst", {bus.req0_ready, bus.req1_ready}, 0);
    clear_logs();
    @(posedge clk); #2 rst = 1'b0;
    wait_idle("t6");
    check_gnts("t6_gnt", '{0, 1, 1});
    check("t6_rsp0", (rsp_log0.size() > 0) ? rsp_log0[0] : 9'h1ff, {1'b0, 8'd101});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
endmodule
